// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the SCPU multi-cycle control unit: state codes, ALU ops,
// instruction fields, datapath select values and the DECODE dispatch function.
package mc_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_I_EXEC   = 4'd8;
    localparam logic [3:0] S_I_WB     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_JAL      = 4'd12;
    localparam logic [3:0] S_JR       = 4'd13;
    localparam logic [3:0] S_HALT     = 4'd14;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD     = 6'h20;
    localparam logic [5:0] F_SUB     = 6'h22;
    localparam logic [5:0] F_SLT     = 6'h2A;
    localparam logic [5:0] F_JR      = 6'h08;
    localparam logic [5:0] F_SYSCALL = 6'h0C;

    localparam logic       MEM_PC     = 1'b0;
    localparam logic       MEM_ALUOUT = 1'b1;
    localparam logic       SRCA_PC    = 1'b0;
    localparam logic       SRCA_REG   = 1'b1;
    localparam logic [1:0] DST_RT     = 2'd0;
    localparam logic [1:0] DST_RD     = 2'd1;
    localparam logic [1:0] DST_R31    = 2'd2;
    localparam logic [1:0] WB_ALUOUT  = 2'd0;
    localparam logic [1:0] WB_MDR     = 2'd1;
    localparam logic [1:0] WB_PC      = 2'd2;
    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;
    localparam logic [1:0] PC_ALU     = 2'd0;
    localparam logic [1:0] PC_ALUOUT  = 2'd1;
    localparam logic [1:0] PC_JUMP    = 2'd2;
    localparam logic [1:0] PC_REG     = 2'd3;

    // Successor of DECODE; anything not recognised ends in HALT.
    function automatic logic [3:0] decode_next(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] nxt;
        nxt = S_HALT;
        case (op)
            OP_LW, OP_SW:     nxt = S_MEM_ADDR;
            OP_ADDI, OP_XORI: nxt = S_I_EXEC;
            OP_BEQ, OP_BNE:   nxt = S_BRANCH;
            OP_J:             nxt = S_JUMP;
            OP_JAL:           nxt = S_JAL;
            OP_RTYPE: begin
                case (fn)
                    F_ADD, F_SUB, F_SLT: nxt = S_R_EXEC;
                    F_JR:                nxt = S_JR;
                    F_SYSCALL:           nxt = S_HALT;
                    default:             nxt = S_HALT;
                endcase
            end
            default:          nxt = S_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Output decode for the control FSM: Moore outputs from the state, plus the
// run-gated FETCH enables and the zero-dependent branch PC write.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic       active,
    input  logic       run,
    input  logic [3:0] state_q,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       reg_we,
    output logic [1:0] reg_dst_sel,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       halted
);

    always_comb begin
        pc_we        = 1'b0;
        ir_we        = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = MEM_PC;
        reg_we       = 1'b0;
        reg_dst_sel  = DST_RT;
        wb_sel       = WB_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_REG;
        alu_op       = ALU_ADD;
        pc_src       = PC_ALU;
        halted       = 1'b0;
        // active is low while reset is held, so nothing is enabled during reset.
        if (active) begin
            case (state_q)
                S_FETCH: if (run) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    alu_src_b = SRCB_FOUR;
                end
                S_DECODE:   alu_src_b = SRCB_IMMSH;
                S_MEM_ADDR: begin
                    alu_src_a = SRCA_REG;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD:   mem_addr_sel = MEM_ALUOUT;
                S_MEM_WB: begin
                    reg_we = 1'b1;
                    wb_sel = WB_MDR;
                end
                S_MEM_WR: begin
                    mem_addr_sel = MEM_ALUOUT;
                    mem_we       = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = SRCA_REG;
                    alu_op    = (funct == F_SUB) ? ALU_SUB :
                                (funct == F_SLT) ? ALU_SLT : ALU_ADD;
                end
                S_R_WB: begin
                    reg_we      = 1'b1;
                    reg_dst_sel = DST_RD;
                end
                S_I_EXEC: begin
                    alu_src_a = SRCA_REG;
                    alu_src_b = SRCB_IMM;
                    alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                end
                S_I_WB:     reg_we = 1'b1;
                S_BRANCH: begin
                    alu_src_a = SRCA_REG;
                    alu_op    = ALU_SUB;
                    pc_src    = PC_ALUOUT;
                    pc_we     = (opcode == OP_BNE) ? ~zero : zero;
                end
                S_JUMP: begin
                    pc_src = PC_JUMP;
                    pc_we  = 1'b1;
                end
                S_JAL: begin
                    pc_src      = PC_JUMP;
                    pc_we       = 1'b1;
                    reg_we      = 1'b1;
                    reg_dst_sel = DST_R31;
                    wb_sel      = WB_PC;
                end
                S_JR: begin
                    pc_src = PC_REG;
                    pc_we  = 1'b1;
                end
                S_HALT:     halted = 1'b1;
                default:    halted = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// SCPU multi-cycle control unit: state register and next-state logic; outputs
// come from mc_ctrl_decode. run only gates the exit from FETCH.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_we,
    output logic               ir_we,
    output logic               mem_we,
    output logic               mem_addr_sel,
    output logic               reg_we,
    output logic [1:0]         reg_dst_sel,
    output logic [1:0]         wb_sel,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               halted,
    output logic [STATE_W-1:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (run) state_d = S_DECODE;
            S_DECODE:   state_d = decode_next(opcode, funct);
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB,
            S_BRANCH, S_JUMP, S_JAL, S_JR:
                        state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = STATE_W'(state_q);

    mc_ctrl_decode u_decode (
        .active       (reset),
        .run          (run),
        .state_q      (state_q),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .pc_we        (pc_we),
        .ir_we        (ir_we),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .reg_we       (reg_we),
        .reg_dst_sel  (reg_dst_sel),
        .wb_sel       (wb_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_src       (pc_src),
        .halted       (halted)
    );

endmodule
